program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
//  Boot-time program loader sitting upstream of risc_cpu. Accepts a byte stream
//  (length, payload, checksum) over a valid/ready handshake and writes the
//  payload into CPU memory at addresses 0..N-1. Holds the CPU in reset until a
//  verified image is loaded. Replaces hierarchical memory preload in system benches.
// PARAMETERS
//  ADDR_WIDTH   5    memory address width (instruction operand field width)
//  DATA_WIDTH   8    memory word / stream byte width
//  DEPTH        32   max image length in words; must equal 2**ADDR_WIDTH
// PORTS
//  clk        in   1           system clock, rising edge
//  rst        in   1           reset, asynchronous, active-high
//  in_valid   in   1           stream byte valid
//  in_data    in   DATA_WIDTH  stream byte
//  in_ready   out  1           loader can accept a byte (combinational from state/halt)
//  cpu_halt   in   1           halt flag from risc_cpu
//  mem_we     out  1           memory write strobe, one cycle per payload word
//  mem_addr   out  ADDR_WIDTH  memory write address
//  mem_wdata  out  DATA_WIDTH  memory write data
//  cpu_rst    out  1           reset to risc_cpu, active-high, registered
//  done       out  1           verified image loaded, CPU released
//  err        out  1           last load failed (bad length or checksum)
// BEHAVIOUR
//  Transfer: a byte is consumed on a rising clk edge with in_valid && in_ready.
//  Reset (async): state=IDLE, cpu_rst=1, mem_we=0, mem_addr=0, mem_wdata=0,
//   done=0, err=0, count=0, sum=0. Reset mid-load aborts. Words already written
//   stay in memory. The next load must restart from a length byte.
//  States:
//   IDLE  : in_ready=1. Length byte L accepted: if 1<=L<=DEPTH -> LOAD (count=0,
//           sum=0, err=0), else -> ERROR.
//   LOAD  : in_ready=1. Each byte B: registered write next cycle (mem_we=1,
//           mem_addr=count, mem_wdata=B). sum=sum+B mod 2**DATA_WIDTH. count++.
//           On the L-th byte -> CHECK.
//   CHECK : in_ready=1. Byte C: C==sum -> RUN, else -> ERROR.
//   RUN   : cpu_rst=0, done=1. in_ready=cpu_halt. Accepted byte is a new length
//           byte, handled as in IDLE. cpu_rst=1 and done=0 from that same edge.
//   ERROR : cpu_rst=1, err=1, done=0, in_ready=1. Length byte handled as in IDLE.
//  cpu_rst, done and err are flops updated on the same edge as the state change.
//   Example: checksum accepted at edge k -> cpu_rst low after edge k.
//  mem_we is high for exactly one cycle per payload byte. Back-to-back payload
//   bytes give back-to-back writes. Gaps in in_valid insert idle cycles only.
//  No write occurs for length or checksum bytes.
//  mem_addr/mem_wdata hold their last value when mem_we=0.
//  count never wraps: L<=DEPTH, so max address is DEPTH-1 (31).
//  cpu_rst stays high in IDLE/LOAD/CHECK/ERROR. The CPU never runs a partial or
//   unverified image.
// TESTING
//  1 Stream 04,B4,55,D6,00,DF back-to-back -> writes (0,B4)(1,55)(2,D6)(3,00) on
//    4 consecutive cycles. cpu_rst falls and done=1 after the DF edge. err=0.
//  2 Same stream, checksum 00 -> no release. err=1, cpu_rst=1, done=0. Then a
//    valid stream -> err clears and done=1.
//  3 Length 00, then length 21h (33) -> ERROR each time, zero mem_we pulses.
//  4 Full image: length 20h, 32 bytes, in_valid toggled every other cycle ->
//    32 writes with addr 0..1F. No address wrap. Release after correct checksum.
//  5 Assert rst after 2 payload bytes -> all outputs at reset values immediately.
//    Memory holds 2 words. A new full stream then loads correctly.
//  6 In RUN with cpu_halt=0 -> in_ready=0 and bytes ignored. Raise cpu_halt and
//    send length 02 -> cpu_rst=1 and done=0 after that edge.
//  System check: load LDA 20/ADD 21/STO 22/HLT as length-4 image, preset mem 20/21
//    =05/03 -> risc_cpu halts with mem[22]=08.

Source files
------------

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Boot-time program loader placed in front of risc_cpu. A byte stream of the
// form  <length L> <L payload bytes> <checksum>  arrives over a valid/ready
// handshake. Payload byte i is written to CPU memory address i, one write
// strobe per byte. The CPU is held in reset until the checksum matches the
// modulo-2**DATA_WIDTH sum of the payload. Only then is it released.
//
// Ports
//   clk        in   1           system clock, rising edge
//   rst        in   1           asynchronous, active-high reset
//   in_valid   in   1           stream byte valid
//   in_data    in   DATA_WIDTH  stream byte
//   in_ready   out  1           loader can accept a byte (combinational)
//   cpu_halt   in   1           halt flag from risc_cpu (gates reload in RUN)
//   mem_we     out  1           memory write strobe, one cycle per payload byte
//   mem_addr   out  ADDR_WIDTH  memory write address (holds when mem_we=0)
//   mem_wdata  out  DATA_WIDTH  memory write data (holds when mem_we=0)
//   cpu_rst    out  1           registered reset to risc_cpu, active-high
//   done       out  1           verified image loaded, CPU released
//   err        out  1           last load failed (bad length or checksum)
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  // DEPTH must equal 2**ADDR_WIDTH and must fit in one stream byte.
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  cpu_halt,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  err
);

  // Length/count width: one bit wider than the address so that a full
  // DEPTH-word image length is representable without wrapping.
  localparam int LW = ADDR_WIDTH + 1;

  localparam logic [DATA_WIDTH-1:0] DEPTH_B = DATA_WIDTH'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] ZERO_B  = {DATA_WIDTH{1'b0}};
  localparam logic [LW-1:0]         ONE_L   = LW'(1);
  localparam logic [LW-1:0]         ZERO_L  = {LW{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  state_t                r_state;
  logic [LW-1:0]         r_len;    // accepted image length L
  logic [LW-1:0]         r_count;  // payload bytes consumed so far
  logic [DATA_WIDTH-1:0] r_sum;    // running payload checksum

  logic w_xfer;
  logic w_len_ok;
  logic w_last;
  logic w_sum_ok;

  // A length byte is usable when it names 1..DEPTH words.
  function automatic logic len_ok(input logic [DATA_WIDTH-1:0] b);
    return (b != ZERO_B) && (b <= DEPTH_B);
  endfunction

  // Checksum accumulate: plain sum, wrapping at the byte width.
  function automatic logic [DATA_WIDTH-1:0] sum_add(
    input logic [DATA_WIDTH-1:0] acc,
    input logic [DATA_WIDTH-1:0] b
  );
    return acc + b;
  endfunction

  // Ready decode: every state accepts except RUN, where a reload is only
  // allowed once the CPU has halted.
  always_comb begin
    in_ready = 1'b1;
    case (r_state)
      ST_RUN:  in_ready = cpu_halt;
      default: in_ready = 1'b1;
    endcase
  end

  // Handshake and per-byte decode helpers.
  always_comb begin
    w_xfer   = in_valid && in_ready;
    w_len_ok = len_ok(in_data);
    // The L-th payload byte is the one that arrives with count == L-1.
    w_last   = (r_count == (r_len - ONE_L));
    w_sum_ok = (in_data == r_sum);
  end

  // Loader FSM with registered memory port and CPU control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_len     <= ZERO_L;
      r_count   <= ZERO_L;
      r_sum     <= ZERO_B;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_WIDTH{1'b0}};
      mem_wdata <= ZERO_B;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse; address/data hold otherwise.
      mem_we <= 1'b0;
      case (r_state)
        // Any of these states treats the next accepted byte as a length.
        // The CPU goes back into reset on the same edge a reload starts.
        ST_IDLE, ST_RUN, ST_ERROR: begin
          if (w_xfer) begin
            cpu_rst <= 1'b1;
            done    <= 1'b0;
            if (w_len_ok) begin
              r_state <= ST_LOAD;
              r_len   <= in_data[LW-1:0];
              r_count <= ZERO_L;
              r_sum   <= ZERO_B;
              err     <= 1'b0;
            end else begin
              r_state <= ST_ERROR;
              err     <= 1'b1;
            end
          end
        end

        ST_LOAD: begin
          if (w_xfer) begin
            mem_we    <= 1'b1;
            mem_addr  <= r_count[ADDR_WIDTH-1:0];
            mem_wdata <= in_data;
            r_sum     <= sum_add(r_sum, in_data);
            r_count   <= r_count + ONE_L;
            if (w_last) begin
              r_state <= ST_CHECK;
            end
          end
        end

        ST_CHECK: begin
          if (w_xfer) begin
            if (w_sum_ok) begin
              r_state <= ST_RUN;
              cpu_rst <= 1'b0;
              done    <= 1'b1;
              err     <= 1'b0;
            end else begin
              r_state <= ST_ERROR;
              cpu_rst <= 1'b1;
              done    <= 1'b0;
              err     <= 1'b1;
            end
          end
        end

        // Unreachable encodings recover to a safe, CPU-held state.
        default: begin
          r_state <= ST_IDLE;
          cpu_rst <= 1'b1;
          done    <= 1'b0;
          err     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Directed stream bench for program_loader. Expected memory writes are queued
// when payload bytes are accepted; an independent monitor pops them whenever
// mem_we is seen. Status outputs are compared against hand-computed values.
// -----------------------------------------------------------------------------
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       cpu_halt;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_rst;
  logic       done;
  logic       err;

  program_loader #(.ADDR_WIDTH(5), .DATA_WIDTH(8), .DEPTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cpu_halt  (cpu_halt),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [12:0] exp_q[$];
  logic [7:0]  mem_model [0:31];
  int          wr_total = 0;
  int          first_wr = -1;
  int          last_wr = -1;
  logic [7:0]  pl[$];
  logic [12:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every write strobe must match the oldest queued expectation
  initial forever begin
    @(negedge clk);
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("mem_write", {19'd0, mem_addr, mem_wdata}, {19'd0, mon_e});
      end
      mem_model[mem_addr] = mem_wdata;
      wr_total++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
    end
  end

  task automatic clr_wr();
    wr_total = 0;
    first_wr = -1;
    last_wr  = -1;
  endtask

  // Present one byte and hold it until it is accepted on a rising edge
  task automatic send_byte(input logic [7:0] b, input bit is_payload, input logic [4:0] addr);
    int w;
    w = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: got in_ready=%0b after 50 cycles, expected 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    if (is_payload) exp_q.push_back({addr, b});
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Length + payload in pl + checksum; outputs checked right after the
  // checksum edge
  task automatic send_image(input logic [7:0] len, input logic [7:0] cs,
                            input bit gaps, input bit pass);
    send_byte(len, 1'b0, 5'd0);
    for (int i = 0; i < pl.size(); i++) begin
      send_byte(pl[i], 1'b1, i[4:0]);
      if (gaps) idle();
    end
    #1;
    chk("cpu_rst_held_before_cs", {31'd0, cpu_rst}, 32'd1);
    send_byte(cs, 1'b0, 5'd0);
    #1;
    chk("cpu_rst_after_cs", {31'd0, cpu_rst}, {31'd0, ~pass});
    chk("done_after_cs",    {31'd0, done},    {31'd0, pass});
    chk("err_after_cs",     {31'd0, err},     {31'd0, ~pass});
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem_model[i] = 8'h00;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    cpu_halt = 1'b1;
    #1;
    // Reset state
    chk("rst_cpu_rst",  {31'd0, cpu_rst},  32'd1);
    chk("rst_done",     {31'd0, done},     32'd0);
    chk("rst_err",      {31'd0, err},      32'd0);
    chk("rst_mem_we",   {31'd0, mem_we},   32'd0);
    chk("rst_addr",     {27'd0, mem_addr}, 32'd0);
    chk("rst_wdata",    {24'd0, mem_wdata}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: good 4-byte image, back-to-back writes on consecutive cycles
    clr_wr();
    pl = '{8'hB4, 8'h55, 8'hD6, 8'h00};
    send_image(8'h04, 8'hDF, 1'b0, 1'b1);
    chk("t1_writes", wr_total, 32'd4);
    chk("t1_span", last_wr - first_wr, 32'd3);

    // 2: bad checksum holds the CPU, then a good image releases it
    clr_wr();
    send_image(8'h04, 8'h00, 1'b0, 1'b0);
    send_image(8'h04, 8'hDF, 1'b0, 1'b1);
    chk("t2_writes", wr_total, 32'd8);

    // 3: illegal lengths 00 and 21h
    clr_wr();
    send_byte(8'h00, 1'b0, 5'd0);
    idle();
    #1;
    chk("t3_len0_err",  {31'd0, err},     32'd1);
    chk("t3_len0_rst",  {31'd0, cpu_rst}, 32'd1);
    chk("t3_len0_done", {31'd0, done},    32'd0);
    send_byte(8'h21, 1'b0, 5'd0);
    idle();
    #1;
    chk("t3_len33_err", {31'd0, err}, 32'd1);
    repeat (2) @(negedge clk);
    chk("t3_no_writes", wr_total, 32'd0);

    // 4: full 32-word image with gaps, payload i at address i, sum 0x1F0
    clr_wr();
    pl = {};
    for (int i = 0; i < 32; i++) pl.push_back(i[7:0]);
    send_image(8'h20, 8'hF0, 1'b1, 1'b1);
    chk("t4_writes", wr_total, 32'd32);
    chk("t4_mem31", {24'd0, mem_model[31]}, 32'h1F);
    chk("t4_mem0",  {24'd0, mem_model[0]},  32'h00);

    // 5: reset after two payload bytes
    clr_wr();
    send_byte(8'h04, 1'b0, 5'd0);
    send_byte(8'hA1, 1'b1, 5'd0);
    send_byte(8'hA2, 1'b1, 5'd1);
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk("t5_mem_we",   {31'd0, mem_we},    32'd0);
    chk("t5_addr",     {27'd0, mem_addr},  32'd0);
    chk("t5_wdata",    {24'd0, mem_wdata}, 32'd0);
    chk("t5_cpu_rst",  {31'd0, cpu_rst},   32'd1);
    chk("t5_done",     {31'd0, done},      32'd0);
    chk("t5_err",      {31'd0, err},       32'd0);
    chk("t5_mem0",     {24'd0, mem_model[0]}, 32'hA1);
    chk("t5_mem1",     {24'd0, mem_model[1]}, 32'hA2);
    chk("t5_mem2",     {24'd0, mem_model[2]}, 32'h02);
    chk("t5_writes",   wr_total, 32'd2);
    @(negedge clk);
    rst = 1'b0;
    pl = '{8'h10, 8'h20, 8'h30};
    send_image(8'h03, 8'h60, 1'b0, 1'b1);
    chk("t5_mem2_new", {24'd0, mem_model[2]}, 32'h30);

    // 6: in RUN, no reload until the CPU halts
    clr_wr();
    @(negedge clk);
    cpu_halt = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h02;
    #1;
    chk("t6_ready_low", {31'd0, in_ready}, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("t6_done_held", {31'd0, done},    32'd1);
    chk("t6_rst_low",   {31'd0, cpu_rst}, 32'd0);
    cpu_halt = 1'b1;
    #1;
    chk("t6_ready_high", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("t6_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("t6_done",    {31'd0, done},    32'd0);
    send_byte(8'h11, 1'b1, 5'd0);
    send_byte(8'h22, 1'b1, 5'd1);
    send_byte(8'h33, 1'b0, 5'd0);
    #1;
    chk("t6_reload_done", {31'd0, done}, 32'd1);
    idle();
    repeat (3) @(negedge clk);
    chk("t6_writes", wr_total, 32'd2);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
